nand_flash_responder: RTL and testbench
=======================================

// Module: nand_flash_responder
// PURPOSE
// Behavioural-synthesizable NAND flash device: the responder end of the flash bus that
// the flash controller drives (F_IO/F_CLE/F_ALE/F_WEN/F_REN/F_RB). Decodes command and
// address cycles, serves page reads, buffers page programs and models ready/busy on F_RB.
// Sits in the testbench/top as the flash the controller talks to.
// PARAMETERS
// MEM_AW     18   byte-address width of the array (2**MEM_AW bytes; page = 512 bytes)
// T_READ     8    clk cycles F_RB stays low after the last read address cycle
// T_PROG     32   clk cycles F_RB stays low after confirm command 8'h10
// T_RST      4    clk cycles F_RB stays low after reset command 8'hFF
// PORTS
// clk    in     1  system clock; every edge detect and state update on its rising edge
// rst    in     1  asynchronous, active-low reset
// F_IO   inout  8  command/address/data bus; driven only during read-data output
// F_CLE  in     1  command latch enable (high: the cycle on F_IO is a command)
// F_ALE  in     1  address latch enable (high: the cycle on F_IO is an address byte)
// F_WEN  in     1  write enable, active low; F_IO is captured on its rising edge
// F_REN  in     1  read enable, active low; output byte valid while low
// F_RB   out    1  ready(1)/busy(0)
// BEHAVIOUR
// - Reset (rst=0): F_RB=1, F_IO high-Z, state IDLE, half=0, addr=0, page buffer all 8'hFF,
//   write mask clear. The array is not cleared by reset. rst going low mid-busy or
//   mid-transfer aborts immediately; a pending program is discarded.
// - Edge detect: register F_WEN/F_REN once on clk; wen_rise = !wen_q & F_WEN,
//   ren_fall = ren_q & !F_REN, ren_rise = !ren_q & F_REN. Bus high/low phases are >=1 clk.
// - On wen_rise with F_CLE=1 (command): FF -> BUSY (T_RST), program aborted;
//   00 -> half=0, state RADDR; 01 -> half=1, state RADDR; 80 -> clear mask, buffer all FF,
//   state PADDR (half kept from preceding 00/01); 10 in PDATA -> BUSY (T_PROG) and commit;
//   any other code -> IDLE.
// - On wen_rise with F_ALE=1: address byte k=0,1,2 in order: A0 -> addr[7:0];
//   A1 -> addr[16:9]; A2 bit0 -> addr[17]; addr[8]=half. Bits at or above MEM_AW ignored.
//   After A2: RADDR -> BUSY (T_READ) then READ; PADDR -> PDATA. A 4th ALE cycle is ignored.
// - Command/address cycles with both F_CLE and F_ALE high: ignored.
// - PDATA: wen_rise with CLE=ALE=0 stores F_IO to buffer[col], sets mask[col], then
//   col = col+1 mod 512 (page-local wrap, row unchanged). Commit on 10: for each col with
//   mask set, array[{row,col}] <= buffer[col]; other bytes untouched. Commit happens when
//   BUSY completes; F_RB rises the same cycle the array is updated.
// - READ: on ren_fall drive F_IO = array[{row,col}] from the next clk; hold while
//   F_REN=0; on ren_rise release F_IO (high-Z) and col = col+1 mod 512. Any command
//   cycle leaves READ.
// - BUSY: F_RB=0 for exactly T_x clk cycles starting the clk after the triggering
//   wen_rise; every WEN/REN cycle except command FF is ignored while busy. FF during
//   BUSY restarts the count with T_RST and cancels the pending commit.
// - F_IO never driven when F_REN=1, F_RB=0, or state != READ (no contention with
//   controller-side writes).
// - States: IDLE, RADDR, PADDR, PDATA, BUSY, READ; BUSY returns to READ (after read),
//   IDLE (after program or reset).
// TESTING
// 1 Reset: rst=0 then 1 -> F_RB=1, F_IO=Z; cmd FF -> F_RB low exactly 4 clk then high.
// 2 Program: 80, A 0x05/0x12/0x01, half=0, data 0xA1,0xB2,0xC3, cmd 10 -> F_RB low
//   32 clk; array[0x22405..0x22407] = A1,B2,C3; array[0x22408] unchanged.
// 3 Read back: 00, same address -> F_RB low 8 clk; three REN pulses return A1,B2,C3.
// 4 Upper half + wrap: 01, A0=0xFF -> reads byte col 511 then col 0 of same page (row kept).
// 5 Busy guard: 80/addr/data, 10, then data cycle 0x55 during busy -> ignored; FF mid-busy
//   -> no commit, F_RB high 4 clk after FF.
// 6 Mid-operation reset: rst=0 during PDATA -> pending bytes discarded, F_RB=1, IDLE.

Source files
------------

// File: rtl/nand_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : nand_flash_responder
// Description : Device end of a raw NAND flash bus. Decodes command/address
//               cycles, serves page reads, buffers page programs and reports
//               ready/busy on F_RB. The page is 512 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_flash_responder #(
   parameter int MEM_AW = 18,
   parameter int T_READ = 8,
   parameter int T_PROG = 32,
   parameter int T_RST  = 4
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire  [7:0] F_IO,
   input  logic       F_CLE,
   input  logic       F_ALE,
   input  logic       F_WEN,
   input  logic       F_REN,
   output logic       F_RB
);

   localparam int PAGE  = 512;
   localparam int DEPTH = 2 ** MEM_AW;

   localparam logic [7:0] c_CMD_RESET  = 8'hFF;
   localparam logic [7:0] c_CMD_READ0  = 8'h00;
   localparam logic [7:0] c_CMD_READ1  = 8'h01;
   localparam logic [7:0] c_CMD_PROG   = 8'h80;
   localparam logic [7:0] c_CMD_CONF   = 8'h10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_PADDR = 3'd2,
      S_PDATA = 3'd3,
      S_BUSY  = 3'd4,
      S_READ  = 3'd5
   } state_t;

   state_t          r_state;
   state_t          r_ret;
   logic            r_wen_q;
   logic            r_ren_q;
   logic            r_half;
   logic            r_commit;
   logic            r_oe;
   logic            r_rb;
   logic [1:0]      r_acnt;
   logic [8:0]      r_row;
   logic [8:0]      r_col;
   logic [15:0]     r_cnt;
   logic [7:0]      r_dout;
   logic [7:0]      r_mem [DEPTH];
   logic [7:0]      r_buf [PAGE];
   logic [PAGE-1:0] r_mask;

   logic w_wen_rise;
   logic w_ren_fall;
   logic w_ren_rise;
   logic w_cmd;
   logic w_adr;
   logic w_dat;
   logic w_reset_cmd;
   logic w_commit;
   logic w_buf_clr;
   logic w_buf_wr;
   logic w_drive;

   assign w_wen_rise  = ~r_wen_q & F_WEN;
   assign w_ren_fall  = r_ren_q & ~F_REN;
   assign w_ren_rise  = ~r_ren_q & F_REN;

   // Cycles with both latch enables high are neither command nor address.
   assign w_cmd       = w_wen_rise & F_CLE & ~F_ALE;
   assign w_adr       = w_wen_rise & F_ALE & ~F_CLE;
   assign w_dat       = w_wen_rise & ~F_CLE & ~F_ALE;
   assign w_reset_cmd = w_cmd & (F_IO == c_CMD_RESET);

   // A reset command landing on the final busy cycle still wins over the commit.
   assign w_commit    = (r_state == S_BUSY) & (r_cnt == 16'd0) & r_commit & ~w_reset_cmd;
   assign w_buf_clr   = w_cmd & (F_IO == c_CMD_PROG) & (r_state != S_BUSY);
   assign w_buf_wr    = w_dat & (r_state == S_PDATA);

   // Bus is only driven while the read strobe is low and the device is ready.
   assign w_drive     = r_oe & ~F_REN & r_rb & (r_state == S_READ);
   assign F_IO        = w_drive ? r_dout : 8'hzz;
   assign F_RB        = r_rb;

   // Main controller: edge detection, command/address decode, busy timing, read output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_ret    <= S_IDLE;
         r_wen_q  <= 1'b1;
         r_ren_q  <= 1'b1;
         r_half   <= 1'b0;
         r_commit <= 1'b0;
         r_oe     <= 1'b0;
         r_rb     <= 1'b1;
         r_acnt   <= 2'd0;
         r_row    <= 9'd0;
         r_col    <= 9'd0;
         r_cnt    <= 16'd0;
         r_dout   <= 8'd0;
      end else begin
         r_wen_q <= F_WEN;
         r_ren_q <= F_REN;
         if (r_state == S_BUSY) begin
            if (w_reset_cmd) begin
               r_cnt    <= 16'(T_RST - 1);
               r_commit <= 1'b0;
               r_ret    <= S_IDLE;
            end else if (r_cnt == 16'd0) begin
               r_rb     <= 1'b1;
               r_commit <= 1'b0;
               r_state  <= r_ret;
            end else begin
               r_cnt <= r_cnt - 16'd1;
            end
         end else if (w_cmd) begin
            r_oe <= 1'b0;
            case (F_IO)
               c_CMD_RESET: begin
                  r_state  <= S_BUSY;
                  r_rb     <= 1'b0;
                  r_cnt    <= 16'(T_RST - 1);
                  r_ret    <= S_IDLE;
                  r_commit <= 1'b0;
               end
               c_CMD_READ0: begin
                  r_half  <= 1'b0;
                  r_acnt  <= 2'd0;
                  r_state <= S_RADDR;
               end
               c_CMD_READ1: begin
                  r_half  <= 1'b1;
                  r_acnt  <= 2'd0;
                  r_state <= S_RADDR;
               end
               c_CMD_PROG: begin
                  r_acnt  <= 2'd0;
                  r_state <= S_PADDR;
               end
               c_CMD_CONF: begin
                  if (r_state == S_PDATA) begin
                     r_state  <= S_BUSY;
                     r_rb     <= 1'b0;
                     r_cnt    <= 16'(T_PROG - 1);
                     r_ret    <= S_IDLE;
                     r_commit <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end else if (w_adr && (r_state == S_RADDR || r_state == S_PADDR)) begin
            r_acnt <= r_acnt + 2'd1;
            case (r_acnt)
               2'd0: r_col <= {r_half, F_IO};
               2'd1: r_row[7:0] <= F_IO;
               default: begin
                  r_row[8] <= F_IO[0];
                  r_col[8] <= r_half;
                  if (r_state == S_RADDR) begin
                     r_state <= S_BUSY;
                     r_rb    <= 1'b0;
                     r_cnt   <= 16'(T_READ - 1);
                     r_ret   <= S_READ;
                  end else begin
                     r_state <= S_PDATA;
                  end
               end
            endcase
         end else if (w_buf_wr) begin
            r_col <= r_col + 9'd1;
         end else if (r_state == S_READ) begin
            if (w_ren_fall) begin
               r_dout <= r_mem[MEM_AW'({r_row, r_col})];
               r_oe   <= 1'b1;
            end else if (w_ren_rise && r_oe) begin
               r_oe  <= 1'b0;
               r_col <= r_col + 9'd1;
            end
         end
      end
   end

   // Page buffer and per-byte write mask collected during the data phase of a program.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PAGE; i++) begin
            r_buf[i] <= 8'hFF;
         end
         r_mask <= '0;
      end else if (w_buf_clr) begin
         for (int i = 0; i < PAGE; i++) begin
            r_buf[i] <= 8'hFF;
         end
         r_mask <= '0;
      end else if (w_buf_wr) begin
         r_buf[r_col]  <= F_IO;
         r_mask[r_col] <= 1'b1;
      end
   end

   // Array commit: only bytes written during the data phase touch the array.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < PAGE; i++) begin
            if (r_mask[i]) begin
               r_mem[MEM_AW'({r_row, 9'(i)})] <= r_buf[i];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nand_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_flash_responder
// Description : Self-checking bench for nand_flash_responder. Programs and
//               reads pages from tables, then walks busy-guard and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_flash_responder;

   localparam int T_READ = 8;
   localparam int T_PROG = 32;
   localparam int T_RST  = 4;

   typedef struct packed {
      logic             half;
      logic [7:0]       a0;
      logic [7:0]       a1;
      logic [7:0]       a2;
      logic [0:2][7:0]  d;
   } prog_t;

   typedef struct packed {
      logic             half;
      logic [7:0]       a0;
      logic [7:0]       a1;
      logic [7:0]       a2;
      logic [2:0]       n;
      logic [0:3][7:0]  exp;
   } rd_t;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       F_CLE   = 1'b0;
   logic       F_ALE   = 1'b0;
   logic       F_WEN   = 1'b1;
   logic       F_REN   = 1'b1;
   logic [7:0] r_tb_io = 8'h00;
   logic       r_tb_oe = 1'b0;
   wire        F_RB;
   wire  [7:0] F_IO;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] sb_q [$];
   prog_t      pt [5];
   rd_t        rt [4];

   assign F_IO = r_tb_oe ? r_tb_io : 8'hzz;

   // Released bus floats to all ones, so a non-FF value means someone is driving.
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (F_IO[g]);
   end

   always #5 clk = ~clk;

   nand_flash_responder #(
      .MEM_AW (18),
      .T_READ (T_READ),
      .T_PROG (T_PROG),
      .T_RST  (T_RST)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .F_IO  (F_IO),
      .F_CLE (F_CLE),
      .F_ALE (F_ALE),
      .F_WEN (F_WEN),
      .F_REN (F_REN),
      .F_RB  (F_RB)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One WEN-strobed bus cycle; the rising edge is seen by the DUT at the next clk.
   task automatic bus_wr(input logic cle, input logic ale, input logic [7:0] v);
      @(posedge clk); #1;
      F_CLE   = cle;
      F_ALE   = ale;
      r_tb_io = v;
      r_tb_oe = 1'b1;
      F_WEN   = 1'b0;
      @(posedge clk); #1;
      F_WEN   = 1'b1;
   endtask

   // Counts busy cycles starting at the clk that detects the preceding WEN rise.
   task automatic measure_busy(input string name, input int exp_low);
      int low;
      low = 0;
      @(posedge clk); #1;
      F_CLE   = 1'b0;
      F_ALE   = 1'b0;
      r_tb_oe = 1'b0;
      for (int i = 0; i < exp_low + 16; i++) begin
         @(negedge clk);
         if (!F_RB) low++;
      end
      check(name, low, exp_low);
      check({name, "_ready"}, F_RB, 1'b1);
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 100 && !F_RB; i++) @(negedge clk);
      check(name, F_RB, 1'b1);
   endtask

   task automatic send_addr(input logic half, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2);
      bus_wr(1'b0, 1'b1, a0);
      bus_wr(1'b0, 1'b1, a1);
      bus_wr(1'b0, 1'b1, a2);
   endtask

   // One REN pulse: the expected byte was queued by the caller, popped when data appears.
   task automatic rd_byte(input string name);
      logic [7:0] exp;
      @(posedge clk); #1;
      F_REN = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         exp = sb_q.pop_front();
         check(name, F_IO, exp);
      end
      @(posedge clk); #1;
      F_REN = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({name, "_release"}, F_IO, 8'hFF);
   endtask

   task automatic read_seq(input string name, input logic half, input logic [7:0] a0,
                           input logic [7:0] a1, input logic [7:0] a2, input int n,
                           input logic [0:3][7:0] exp);
      bus_wr(1'b1, 1'b0, half ? 8'h01 : 8'h00);
      send_addr(half, a0, a1, a2);
      measure_busy({name, "_tread"}, T_READ);
      for (int i = 0; i < n; i++) begin
         sb_q.push_back(exp[i]);
         rd_byte($sformatf("%s_b%0d", name, i));
      end
   endtask

   task automatic program3(input prog_t p, input int idx);
      bus_wr(1'b1, 1'b0, p.half ? 8'h01 : 8'h00);
      bus_wr(1'b1, 1'b0, 8'h80);
      send_addr(p.half, p.a0, p.a1, p.a2);
      for (int i = 0; i < 3; i++) bus_wr(1'b0, 1'b0, p.d[i]);
      bus_wr(1'b1, 1'b0, 8'h10);
      measure_busy($sformatf("prog%0d_tprog", idx), T_PROG);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Program table: 0x22408.. first so that 0x22408 holds a known byte later.
      pt[0] = '{half: 1'b0, a0: 8'h08, a1: 8'h12, a2: 8'h01, d: '{8'h77, 8'h88, 8'h99}};
      pt[1] = '{half: 1'b0, a0: 8'h05, a1: 8'h12, a2: 8'h01, d: '{8'hA1, 8'hB2, 8'hC3}};
      pt[2] = '{half: 1'b1, a0: 8'hFF, a1: 8'h03, a2: 8'h00, d: '{8'h5A, 8'h6B, 8'h7C}};
      pt[3] = '{half: 1'b0, a0: 8'h00, a1: 8'h00, a2: 8'h00, d: '{8'h11, 8'h22, 8'h33}};
      pt[4] = '{half: 1'b0, a0: 8'h00, a1: 8'h10, a2: 8'h00, d: '{8'h44, 8'h45, 8'h46}};
      // Read table: 0x22405..0x22408, page wrap col 511 -> 0 -> 1 of row 3, etc.
      rt[0] = '{half: 1'b0, a0: 8'h05, a1: 8'h12, a2: 8'h01, n: 3'd4,
                exp: '{8'hA1, 8'hB2, 8'hC3, 8'h77}};
      rt[1] = '{half: 1'b1, a0: 8'hFF, a1: 8'h03, a2: 8'h00, n: 3'd3,
                exp: '{8'h5A, 8'h6B, 8'h7C, 8'h00}};
      rt[2] = '{half: 1'b0, a0: 8'h00, a1: 8'h00, a2: 8'h00, n: 3'd3,
                exp: '{8'h11, 8'h22, 8'h33, 8'h00}};
      rt[3] = '{half: 1'b0, a0: 8'h00, a1: 8'h10, a2: 8'h00, n: 3'd3,
                exp: '{8'h44, 8'h45, 8'h46, 8'h00}};

      // Reset state and reset command timing
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rb", F_RB, 1'b1);
      check("rst_io", F_IO, 8'hFF);
      #1 rst = 1'b1;
      @(negedge clk);
      check("post_rst_rb", F_RB, 1'b1);
      bus_wr(1'b1, 1'b0, 8'hFF);
      measure_busy("cmd_ff_trst", T_RST);

      // Table-driven programs and read-backs
      for (int i = 0; i < 5; i++) program3(pt[i], i);
      for (int i = 0; i < 4; i++) begin
         read_seq($sformatf("rd%0d", i), rt[i].half, rt[i].a0, rt[i].a1, rt[i].a2,
                  int'(rt[i].n), rt[i].exp);
      end

      // Data cycle during program busy must not reach the buffer
      bus_wr(1'b1, 1'b0, 8'h00);
      bus_wr(1'b1, 1'b0, 8'h80);
      send_addr(1'b0, 8'h00, 8'h10, 8'h00);
      bus_wr(1'b0, 1'b0, 8'hEE);
      bus_wr(1'b1, 1'b0, 8'h10);
      bus_wr(1'b0, 1'b0, 8'h55);
      wait_ready("guard_ready");
      read_seq("guard", 1'b0, 8'h00, 8'h10, 8'h00, 2, '{8'hEE, 8'h45, 8'h00, 8'h00});

      // Reset command mid-program cancels the commit and restarts busy timing
      bus_wr(1'b1, 1'b0, 8'h80);
      send_addr(1'b0, 8'h00, 8'h10, 8'h00);
      bus_wr(1'b0, 1'b0, 8'h99);
      bus_wr(1'b1, 1'b0, 8'h10);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("prog_busy_before_ff", F_RB, 1'b0);
      bus_wr(1'b1, 1'b0, 8'hFF);
      measure_busy("ff_midbusy", T_RST);
      read_seq("nocommit", 1'b0, 8'h00, 8'h10, 8'h00, 1, '{8'hEE, 8'h00, 8'h00, 8'h00});

      // Hardware reset during the data phase discards the pending page
      bus_wr(1'b1, 1'b0, 8'h80);
      send_addr(1'b0, 8'h00, 8'h10, 8'h00);
      bus_wr(1'b0, 1'b0, 8'h12);
      @(posedge clk); #1;
      rst     = 1'b0;
      r_tb_oe = 1'b0;
      F_CLE   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_rb", F_RB, 1'b1);
      check("midrst_io", F_IO, 8'hFF);
      #1 rst = 1'b1;
      bus_wr(1'b1, 1'b0, 8'h10);
      measure_busy("midrst_no_prog", 0);
      read_seq("midrst_rd", 1'b0, 8'h00, 8'h10, 8'h00, 1, '{8'hEE, 8'h00, 8'h00, 8'h00});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
